mem_port_arbiter: RTL

Shares one memory request/response bus between the core's instruction-fetch port and its load/store port. Sits between the pipeline core and the bus/AXI bridge. Serialises fetch, load and store requests onto the bus. Generates the core's stall_if/stall_mem signals. Returns fetched instructions and load data through registers.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_prio.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned BUS_ARB_STATE_W  = 2;
   localparam int unsigned BUS_STARVE_CNT_W = 4;

   typedef enum logic [BUS_ARB_STATE_W-1:0] {
      ArbIdle = 2'd0,
      ArbReq  = 2'd1,
      ArbResp = 2'd2,
      ArbDone = 2'd3
   } arb_state_e;

   typedef enum logic {
      OwnIf  = 1'b0,
      OwnMem = 1'b1
   } owner_e;

   // Increment that sticks at max instead of wrapping.
   function automatic logic [BUS_STARVE_CNT_W-1:0] sat_inc(
      input logic [BUS_STARVE_CNT_W-1:0] cnt,
      input logic [BUS_STARVE_CNT_W-1:0] max
   );
      return (cnt >= max) ? max : cnt + BUS_STARVE_CNT_W'(1);
   endfunction

endpackage

// File: rtl/mem_port_prio.sv
// Grant selection between fetch and load/store, with fetch starvation guard.
module mem_port_prio
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   arb_en_i,
   input  logic   instr_rd_en_i,
   input  logic   mem_rd_en_i,
   input  logic   mem_wr_en_i,
   output logic   grant_o,
   output owner_e grant_owner_o,
   output logic   grant_we_o
);

   localparam logic [BUS_STARVE_CNT_W-1:0] StarveMax = BUS_STARVE_CNT_W'(STARVE_MAX);

   logic [BUS_STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                        data_pend;

   assign data_pend = mem_rd_en_i | mem_wr_en_i;

   // Data side wins unless it has already starved a pending fetch; store beats load.
   always_comb begin
      grant_o       = 1'b0;
      grant_owner_o = OwnIf;
      grant_we_o    = 1'b0;
      if (data_pend && ((starve_cnt_q < StarveMax) || !instr_rd_en_i)) begin
         grant_o       = arb_en_i;
         grant_owner_o = OwnMem;
         grant_we_o    = mem_wr_en_i;
      end else if (instr_rd_en_i) begin
         grant_o       = arb_en_i;
         grant_owner_o = OwnIf;
      end
   end

   // Count data grants made while a fetch waits; any other grant clears it.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_o) begin
         if (grant_owner_o == OwnMem && instr_rd_en_i) begin
            starve_cnt_d = sat_inc(starve_cnt_q, StarveMax);
         end else begin
            starve_cnt_d = '0;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store onto one request/response bus.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned INSTR_W    = 32,
   parameter int unsigned STRB_W     = DATA_W / 8,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_rd_en_i,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic               mem_rd_en_i,
   input  logic               mem_wr_en_i,
   input  logic [ADDR_W-1:0]  addr_mem_rd_i,
   input  logic [ADDR_W-1:0]  addr_mem_wr_i,
   input  logic [DATA_W-1:0]  data_mem_wr_i,
   input  logic [STRB_W-1:0]  strb_mem_wr_i,
   output logic               stall_if_o,
   output logic               stall_mem_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [DATA_W-1:0]  data_mem_o,
   output logic               err_if_o,
   output logic               err_mem_o,
   output logic               bus_req_valid_o,
   input  logic               bus_req_ready_i,
   output logic               bus_req_we_o,
   output logic [ADDR_W-1:0]  bus_req_addr_o,
   output logic [DATA_W-1:0]  bus_req_wdata_o,
   output logic [STRB_W-1:0]  bus_req_strb_o,
   input  logic               bus_rsp_valid_i,
   input  logic [DATA_W-1:0]  bus_rsp_data_i,
   input  logic               bus_rsp_err_i
);

   arb_state_e         state_q, state_d;
   owner_e             owner_q, owner_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [STRB_W-1:0]  strb_q, strb_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               err_if_q, err_if_d;
   logic               err_mem_q, err_mem_d;

   logic   arb_en;
   logic   grant;
   owner_e grant_owner;
   logic   grant_we;
   logic   done;

   assign arb_en = (state_q == ArbIdle);
   assign done   = (state_q == ArbDone);

   mem_port_prio #(
      .STARVE_MAX(STARVE_MAX)
   ) u_prio (
      .clk          (clk),
      .rst_n        (rst_n),
      .arb_en_i     (arb_en),
      .instr_rd_en_i(instr_rd_en_i),
      .mem_rd_en_i  (mem_rd_en_i),
      .mem_wr_en_i  (mem_wr_en_i),
      .grant_o      (grant),
      .grant_owner_o(grant_owner),
      .grant_we_o   (grant_we)
   );

   // Stalls release only in the owner's DONE cycle; gated by reset so they read 0 in reset.
   assign stall_if_o  = rst_n & instr_rd_en_i & ~(done & (owner_q == OwnIf));
   assign stall_mem_o = rst_n & (mem_rd_en_i | mem_wr_en_i) & ~(done & (owner_q == OwnMem));

   assign bus_req_valid_o = (state_q == ArbReq);
   assign bus_req_we_o    = we_q;
   assign bus_req_addr_o  = addr_q;
   assign bus_req_wdata_o = wdata_q;
   assign bus_req_strb_o  = strb_q;

   assign instr_o    = instr_q;
   assign data_mem_o = data_q;
   assign err_if_o   = err_if_q;
   assign err_mem_o  = err_mem_q;

   // Transaction FSM: latch request on grant, hold it through REQ, capture response in RESP.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      instr_d   = instr_q;
      data_d    = data_q;
      err_if_d  = 1'b0;
      err_mem_d = 1'b0;
      unique case (state_q)
         ArbIdle: begin
            if (grant) begin
               state_d = ArbReq;
               owner_d = grant_owner;
               if (grant_owner == OwnMem) begin
                  we_d    = grant_we;
                  addr_d  = grant_we ? addr_mem_wr_i : addr_mem_rd_i;
                  wdata_d = grant_we ? data_mem_wr_i : '0;
                  strb_d  = grant_we ? strb_mem_wr_i : '0;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = pc_i;
                  wdata_d = '0;
                  strb_d  = '0;
               end
            end
         end
         ArbReq: begin
            if (bus_req_ready_i) begin
               state_d = ArbResp;
            end
         end
         ArbResp: begin
            if (bus_rsp_valid_i) begin
               state_d = ArbDone;
               if (owner_q == OwnIf) begin
                  instr_d  = bus_rsp_data_i[INSTR_W-1:0];
                  err_if_d = bus_rsp_err_i;
               end else begin
                  if (!we_q) begin
                     data_d = bus_rsp_data_i;
                  end
                  err_mem_d = bus_rsp_err_i;
               end
            end
         end
         ArbDone: begin
            // Core still shows the finished request this cycle, so never re-arbitrate here.
            state_d = ArbIdle;
         end
         default: begin
            state_d = ArbIdle;
         end
      endcase
   end

   // State, latched request and captured response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ArbIdle;
         owner_q   <= OwnIf;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         instr_q   <= '0;
         data_q    <= '0;
         err_if_q  <= 1'b0;
         err_mem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         instr_q   <= instr_d;
         data_q    <= data_d;
         err_if_q  <= err_if_d;
         err_mem_q <= err_mem_d;
      end
   end

endmodule
